// File: rtl/imu_frame_pkg.sv
// Shared types and constants for the IMU binary frame packer.
package imu_frame_pkg;

    // Byte currently presented on the stream, or IDLE when nothing is in flight
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_SEQ,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } state_t;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

    // Width of the frame and drop counters
    localparam int CNT_W = 16;

    // Payload byte count for a given channel layout
    function automatic int payload_len(input int num_ch, input int sample_w);
        return num_ch * (sample_w / 8);
    endfunction

    // Header (sync x2, seq, len) plus payload plus checksum
    function automatic int frame_len(input int num_ch, input int sample_w);
        return payload_len(num_ch, sample_w) + 5;
    endfunction

endpackage

// File: rtl/imu_decimator.sv
// Sample decimator: flags one sample out of every decim_i+1 valid strobes.
module imu_decimator #(
    parameter int DECIM_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               sample_valid_i,
    input  logic [DECIM_W-1:0] decim_i,
    output logic               eligible_o
);

    logic [DECIM_W-1:0] dcnt;

    // Comparing with >= means a decim_i lowered below dcnt lets the next sample through
    assign eligible_o = sample_valid_i && enable_i && (dcnt >= decim_i);

    // Count valid strobes between eligible samples; parked at zero while disabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dcnt <= '0;
        end else if (!enable_i) begin
            dcnt <= '0;
        end else if (sample_valid_i) begin
            if (dcnt >= decim_i) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imu_frame_packer.sv
// IMU frame packer: snapshots a sample vector and streams it as a
// checksummed binary frame over a byte-wide valid/ready interface.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | no frame in flight, waiting for eligible sample
//   ST_SYNC0   | presenting first sync byte
//   ST_SYNC1   | presenting second sync byte
//   ST_SEQ     | presenting sequence number
//   ST_LEN     | presenting payload length
//   ST_PAYLOAD | presenting payload byte idx (ch0 MSB first)
//   ST_CHK     | presenting checksum; handshake completes the frame
module imu_frame_packer
    import imu_frame_pkg::*;
#(
    parameter int         NUM_CH   = 7,
    parameter int         SAMPLE_W = 16,
    parameter int         DECIM_W  = 8,
    parameter logic [7:0] SYNC0    = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1    = SYNC1_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_i,
    input  logic                       sample_valid_i,
    input  logic                       enable_i,
    input  logic [DECIM_W-1:0]         decim_i,
    output logic [7:0]                 byte_o,
    output logic                       byte_valid_o,
    input  logic                       byte_ready_i,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           frames_sent_o,
    output logic [CNT_W-1:0]           drop_cnt_o,
    output logic                       led_activity_o
);

    localparam int         LEN      = payload_len(NUM_CH, SAMPLE_W);
    localparam int         SNAP_W   = NUM_CH * SAMPLE_W;
    localparam logic [7:0] LEN_B    = 8'(LEN);
    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    state_t              state;
    logic [SNAP_W-1:0]   snap;
    logic [7:0]          acc;
    logic [7:0]          idx;
    logic [7:0]          seq;
    logic                eligible;
    logic                hs;

    imu_decimator #(
        .DECIM_W (DECIM_W)
    ) u_decim (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .sample_valid_i (sample_valid_i),
        .decim_i        (decim_i),
        .eligible_o     (eligible)
    );

    assign hs     = byte_valid_o && byte_ready_i;
    assign busy_o = (state != ST_IDLE);

    // Frame sequencer: each handshake loads the next byte into the output register.
    // The snapshot is consumed by shifting left, so its top byte is always the next payload byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            byte_o         <= '0;
            byte_valid_o   <= 1'b0;
            snap           <= '0;
            acc            <= '0;
            idx            <= '0;
            seq            <= '0;
            frames_sent_o  <= '0;
            led_activity_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (eligible) begin
                        snap         <= sample_i;
                        acc          <= '0;
                        byte_o       <= SYNC0;
                        byte_valid_o <= 1'b1;
                        state        <= ST_SYNC0;
                    end
                end
                ST_SYNC0: begin
                    if (hs) begin
                        byte_o <= SYNC1;
                        state  <= ST_SYNC1;
                    end
                end
                ST_SYNC1: begin
                    if (hs) begin
                        byte_o <= seq;
                        state  <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (hs) begin
                        acc    <= acc + byte_o;
                        byte_o <= LEN_B;
                        state  <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (hs) begin
                        acc    <= acc + byte_o;
                        byte_o <= snap[SNAP_W-1 -: 8];
                        snap   <= snap << 8;
                        idx    <= '0;
                        state  <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (hs) begin
                        acc <= acc + byte_o;
                        if (idx == LAST_IDX) begin
                            // checksum includes the byte completing right now
                            byte_o <= acc + byte_o;
                            state  <= ST_CHK;
                        end else begin
                            byte_o <= snap[SNAP_W-1 -: 8];
                            snap   <= snap << 8;
                            idx    <= idx + 1'b1;
                        end
                    end
                end
                ST_CHK: begin
                    if (hs) begin
                        byte_valid_o   <= 1'b0;
                        seq            <= seq + 1'b1;
                        frames_sent_o  <= frames_sent_o + 1'b1;
                        led_activity_o <= ~led_activity_o;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    byte_valid_o <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of eligible samples that arrive while a frame is in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
        end else if (eligible && (state != ST_IDLE) && (drop_cnt_o != '1)) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_imu_frame_packer.sv
// Scoreboard bench for imu_frame_packer (2 channels x 16 bits).
module tb_imu_frame_packer;

    localparam int NUM_CH   = 2;
    localparam int SAMPLE_W = 16;
    localparam int DECIM_W  = 8;
    localparam int LEN      = NUM_CH * SAMPLE_W / 8;
    localparam int SW       = NUM_CH * SAMPLE_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [SW-1:0]      sample = '0;
    logic               sample_valid = 1'b0;
    logic               enable = 1'b0;
    logic [DECIM_W-1:0] decim = '0;
    logic [7:0]         byte_out;
    logic               byte_valid;
    logic               byte_ready = 1'b0;
    logic               busy;
    logic [15:0]        frames_sent;
    logic [15:0]        drop_cnt;
    logic               led;

    imu_frame_packer #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .DECIM_W  (DECIM_W),
        .SYNC0    (8'hA5),
        .SYNC1    (8'h5A)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .enable_i       (enable),
        .decim_i        (decim),
        .byte_o         (byte_out),
        .byte_valid_o   (byte_valid),
        .byte_ready_i   (byte_ready),
        .busy_o         (busy),
        .frames_sent_o  (frames_sent),
        .drop_cnt_o     (drop_cnt),
        .led_activity_o (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    int         m_remaining = 0;
    int         m_since     = 0;
    int         m_seq       = 0;
    int         m_frames    = 0;
    int         m_drop      = 0;
    bit         m_led       = 1'b0;
    bit         m_inflight;
    bit         m_elig;
    int         m_sum;
    logic [7:0] m_b;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Reference model: a frame occupies the link for LEN+5 accepted bytes after acceptance
    always @(posedge clk) begin
        if (rst) begin
            m_remaining = 0;
            m_since     = 0;
            m_seq       = 0;
            m_frames    = 0;
            m_drop      = 0;
            m_led       = 1'b0;
            exp_q.delete();
        end else begin
            m_inflight = (m_remaining > 0);
            if (m_inflight && byte_ready) begin
                m_remaining--;
                if (m_remaining == 0) begin
                    m_frames++;
                    m_led = ~m_led;
                    m_seq = (m_seq + 1) % 256;
                end
            end
            m_elig = 1'b0;
            if (!enable) begin
                m_since = 0;
            end else if (sample_valid) begin
                m_since++;
                if (m_since > int'(decim)) begin
                    m_elig  = 1'b1;
                    m_since = 0;
                end
            end
            if (m_elig) begin
                if (m_inflight) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(8'h5A);
                    exp_q.push_back(8'(m_seq));
                    exp_q.push_back(8'(LEN));
                    m_sum = m_seq + LEN;
                    for (int k = 0; k < LEN; k++) begin
                        m_b = 8'(sample >> ((LEN - 1 - k) * 8));
                        exp_q.push_back(m_b);
                        m_sum += int'(m_b);
                    end
                    exp_q.push_back(8'(m_sum));
                    m_remaining = LEN + 5;
                end
            end
        end
    end

    bit         stall_prev = 1'b0;
    logic [7:0] stall_byte = '0;

    // Monitor: outputs are stable at the falling edge; a visible valid&&ready completes at the next rise
    always @(negedge clk) begin
        chk("byte_valid", 32'(byte_valid), 32'(m_remaining > 0));
        chk("busy", 32'(busy), 32'(m_remaining > 0));
        chk("frames_sent", 32'(frames_sent), 32'(m_frames & 16'hFFFF));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("led", 32'(led), 32'(m_led));
        if (stall_prev) begin
            chk("stall_valid", 32'(byte_valid), 32'd1);
            chk("stall_hold", 32'(byte_out), 32'(stall_byte));
        end
        stall_prev = 1'b0;
        if (!rst && byte_valid) begin
            if (byte_ready) begin
                got_q.push_back(byte_out);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got byte %0h expected none", byte_out);
                end else begin
                    chk("byte", 32'(byte_out), 32'(exp_q.pop_front()));
                end
            end else begin
                stall_prev = 1'b1;
                stall_byte = byte_out;
            end
        end
    end

    bit rand_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        if (rand_ready) byte_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic strobe(input logic [SW-1:0] s);
        sample       = s;
        sample_valid = 1'b1;
        tick();
        sample = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && m_remaining > 0; i++) tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    logic [7:0] t1_exp[9] = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h12, 8'h34, 8'hFF, 8'h80, 8'hC9};

    initial begin
        repeat (3) tick();
        chk("reset_valid", 32'(byte_valid), 32'd0);
        chk("reset_frames", 32'(frames_sent), 32'd0);
        chk("reset_led", 32'(led), 32'd0);
        rst        = 1'b0;
        enable     = 1'b1;
        byte_ready = 1'b1;
        tick();

        // basic frame, literal expected bytes
        got_q.delete();
        strobe({16'h1234, 16'hFF80});
        drain();
        chk("t1_count", 32'(got_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) chk("t1_byte", 32'(got_q[i]), 32'(t1_exp[i]));
        chk("t1_frames", 32'(frames_sent), 32'd1);

        // same sample under random backpressure
        rand_ready = 1'b1;
        strobe({16'h1234, 16'hFF80});
        drain();
        rand_ready = 1'b0;
        byte_ready = 1'b1;
        tick();

        // decimation by 4
        do_reset();
        decim = 8'd3;
        for (int i = 0; i < 12; i++) begin
            strobe($urandom);
            repeat (19) tick();
        end
        drain();
        chk("t3_frames", 32'(frames_sent), 32'd3);
        chk("t3_drops", 32'(drop_cnt), 32'd0);

        // drops during a long stall
        do_reset();
        decim      = 8'd0;
        byte_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i % 20 == 5) strobe($urandom);
            else tick();
        end
        chk("t4_drops", 32'(drop_cnt), 32'd4);
        chk("t4_frames_stalled", 32'(frames_sent), 32'd0);
        byte_ready = 1'b1;
        drain();
        chk("t4_frames", 32'(frames_sent), 32'd1);

        // sequence wrap over 256 frames
        do_reset();
        for (int i = 0; i < 256; i++) begin
            strobe($urandom);
            repeat (LEN + 5) tick();
        end
        drain();
        chk("t5_frames", 32'(frames_sent), 32'd256);
        chk("t5_led", 32'(led), 32'd0);
        chk("t5_drops", 32'(drop_cnt), 32'd0);

        // reset in the middle of the payload
        do_reset();
        strobe($urandom);
        for (int i = 0; i < 50 && m_remaining != 3; i++) tick();
        chk("t6_in_payload", 32'(m_remaining), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 32'(byte_valid), 32'd0);
        chk("t6_frames", 32'(frames_sent), 32'd0);
        tick();
        strobe($urandom);
        drain();
        chk("t6_frames_after", 32'(frames_sent), 32'd1);

        // random traffic: enable, decimation, strobes and backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 63) == 0) decim = 8'($urandom_range(0, 3));
            sample       = $urandom;
            sample_valid = ($urandom_range(0, 2) == 0);
            tick();
        end
        rand_ready = 1'b0;
        byte_ready = 1'b1;
        enable     = 1'b0;
        drain();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
